// File: rtl/cvxif_pkg.sv
// cvxif_pkg: shared types and defaults for the CV-X-IF offload unit.
package cvxif_pkg;
    localparam int XLEN_DEF = 32;
    localparam int TIMEOUT_CYCLES_DEF = 255;
    localparam logic [6:0] CUSTOM3_OPCODE = 7'b1111011;
    typedef enum logic [2:0] {IDLE, ISSUE, REGS, WAITRES, RESP} state_t;
    function automatic int cnt_width(input int n);
        return n < 2 ? 1 : $clog2(n);
    endfunction
    localparam int TIMEOUT_W_DEF = cnt_width(TIMEOUT_CYCLES_DEF);
endpackage

// File: rtl/cvxif_timeout.sv
// cvxif_timeout: per-phase wait counter; expired on the last allowed cycle of a phase.
module cvxif_timeout import cvxif_pkg::*; #(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int CW = cnt_width(TIMEOUT_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [CW-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else if (clear) cnt_q <= '0;
        else if (enable) cnt_q <= cnt_q + CW'(1);
    end
    assign expired = enable && cnt_q == CW'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/cvxif_offload.sv
// cvxif_offload: forwards one instruction at a time from the core to a CV-X-IF
// coprocessor through issue, register and result phases, with a per-phase timeout.
module cvxif_offload import cvxif_pkg::*; #(
    parameter int XLEN = XLEN_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     req_instr,
    input  logic [XLEN-1:0] req_rs0,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [4:0]      req_rd,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_accept,
    output logic            rsp_error,
    output logic            rsp_we,
    output logic [4:0]      rsp_rd,
    output logic [XLEN-1:0] rsp_data,
    output logic            issue_valid,
    input  logic            issue_ready,
    output logic [31:0]     issue_req_instr,
    input  logic            issue_resp_accept,
    input  logic            issue_resp_writeback,
    input  logic [1:0]      issue_resp_register_read,
    output logic            register_valid,
    input  logic            register_ready,
    output logic [XLEN-1:0] register_rs0,
    output logic [XLEN-1:0] register_rs1,
    output logic [1:0]      register_rs_valid,
    input  logic            result_valid,
    output logic            result_ready,
    input  logic [XLEN-1:0] result_data
);
    state_t          state_q;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] rs0_q, rs1_q, data_q;
    logic [4:0]      rd_q;
    logic [1:0]      mask_q;
    logic            acc_q, wb_q, we_q, err_q, expired;

    // Counter restarts whenever a new phase begins: from IDLE or on each phase handshake.
    cvxif_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk(clk),
        .rst_n(rst_n),
        .clear(state_q == IDLE || (issue_valid && issue_ready) || (register_valid && register_ready)),
        .enable(issue_valid || register_valid || result_ready),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            instr_q <= '0;
            rs0_q   <= '0;
            rs1_q   <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            acc_q   <= 1'b0;
            wb_q    <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    instr_q <= req_instr;
                    rs0_q   <= req_rs0;
                    rs1_q   <= req_rs1;
                    rd_q    <= req_rd;
                    data_q  <= '0;
                    acc_q   <= 1'b0;
                    we_q    <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= ISSUE;
                end
                ISSUE: if (issue_ready) begin
                    acc_q   <= issue_resp_accept;
                    wb_q    <= issue_resp_writeback;
                    mask_q  <= issue_resp_register_read;
                    state_q <= !issue_resp_accept ? RESP :
                               issue_resp_register_read != 2'b00 ? REGS :
                               issue_resp_writeback ? WAITRES : RESP;
                end else if (expired) begin
                    err_q   <= 1'b1;
                    state_q <= RESP;
                end
                REGS: if (register_ready) state_q <= wb_q ? WAITRES : RESP;
                else if (expired) begin
                    err_q   <= 1'b1;
                    state_q <= RESP;
                end
                WAITRES: if (result_valid) begin
                    data_q  <= result_data;
                    we_q    <= 1'b1;
                    state_q <= RESP;
                end else if (expired) begin
                    err_q   <= 1'b1;
                    state_q <= RESP;
                end
                RESP: if (rsp_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready         = rst_n && state_q == IDLE;
    assign issue_valid       = state_q == ISSUE;
    assign issue_req_instr   = issue_valid ? instr_q : '0;
    assign register_valid    = state_q == REGS;
    assign register_rs_valid = register_valid ? mask_q : 2'b00;
    assign register_rs0      = register_valid && mask_q[0] ? rs0_q : '0;
    assign register_rs1      = register_valid && mask_q[1] ? rs1_q : '0;
    assign result_ready      = state_q == WAITRES;
    assign rsp_valid         = state_q == RESP;
    assign rsp_accept        = rsp_valid && acc_q;
    assign rsp_error         = rsp_valid && err_q;
    assign rsp_we            = rsp_valid && we_q;
    assign rsp_rd            = rsp_valid ? rd_q : '0;
    assign rsp_data          = rsp_valid ? data_q : '0;
endmodule

// File: tb/tb_cvxif_offload.sv
// tb_cvxif_offload: table-driven transactions against a scripted coprocessor, plus reset and backpressure sequences.
module tb_cvxif_offload;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0, req_ready;
    logic [31:0]     req_instr = '0;
    logic [XLEN-1:0] req_rs0 = '0, req_rs1 = '0;
    logic [4:0]      req_rd = '0;
    logic            rsp_valid, rsp_ready = 1'b0, rsp_accept, rsp_error, rsp_we;
    logic [4:0]      rsp_rd;
    logic [XLEN-1:0] rsp_data;
    logic            issue_valid, issue_ready = 1'b0;
    logic [31:0]     issue_req_instr;
    logic            issue_resp_accept = 1'b0, issue_resp_writeback = 1'b0;
    logic [1:0]      issue_resp_register_read = '0;
    logic            register_valid, register_ready = 1'b0;
    logic [XLEN-1:0] register_rs0, register_rs1;
    logic [1:0]      register_rs_valid;
    logic            result_valid = 1'b0, result_ready;
    logic [XLEN-1:0] result_data = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cvxif_offload #(.XLEN(XLEN), .TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_instr(req_instr),
        .req_rs0(req_rs0), .req_rs1(req_rs1), .req_rd(req_rd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_accept(rsp_accept),
        .rsp_error(rsp_error), .rsp_we(rsp_we), .rsp_rd(rsp_rd), .rsp_data(rsp_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_req_instr(issue_req_instr),
        .issue_resp_accept(issue_resp_accept), .issue_resp_writeback(issue_resp_writeback),
        .issue_resp_register_read(issue_resp_register_read),
        .register_valid(register_valid), .register_ready(register_ready),
        .register_rs0(register_rs0), .register_rs1(register_rs1), .register_rs_valid(register_rs_valid),
        .result_valid(result_valid), .result_ready(result_ready), .result_data(result_data)
    );

    typedef struct {
        logic [31:0]     instr;
        logic [XLEN-1:0] rs0, rs1;
        logic [4:0]      rd;
        logic            acc, wb;
        logic [1:0]      mask;
        logic [XLEN-1:0] res;
        int              iss_wait;
        int              delay;
        logic            noise;
        logic            exp_reg;
        logic [XLEN-1:0] exp_rs0, exp_rs1;
        logic            exp_acc, exp_we, exp_err;
        logic [XLEN-1:0] exp_data;
        int              exp_lat;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full transaction; the coprocessor side is driven from the table entry each cycle.
    task automatic run(input vec_t v, input int hold);
        int c, ic, wc;
        logic seen, bad;
        logic [1:0] mk;
        logic [XLEN-1:0] r0, r1;
        ic = 0; wc = 0; seen = 1'b0; bad = 1'b0; mk = '0; r0 = '0; r1 = '0;
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_instr = v.instr; req_rs0 = v.rs0; req_rs1 = v.rs1; req_rd = v.rd;
        @(negedge clk);
        req_valid = 1'b0;
        for (c = 1; c < 600 && !rsp_valid; c++) begin
            if (issue_valid) begin
                if (issue_req_instr !== v.instr) bad = 1'b1;
                issue_ready = ic == v.iss_wait;
                issue_resp_accept = v.acc;
                issue_resp_writeback = v.wb;
                issue_resp_register_read = v.mask;
                ic++;
            end else issue_ready = 1'b0;
            if (register_valid) begin
                seen = 1'b1; mk = register_rs_valid; r0 = register_rs0; r1 = register_rs1;
            end
            register_ready = register_valid;
            if (result_ready) begin
                result_valid = wc == v.delay;
                result_data = v.res;
                wc++;
            end else begin
                result_valid = v.noise;
                result_data = 32'hBAD0BAD0;
            end
            @(negedge clk);
        end
        issue_ready = 1'b0; register_ready = 1'b0; result_valid = v.noise; result_data = 32'hBAD0BAD0;
        chk("rsp_valid", rsp_valid, 1);
        chk("latency", c, v.exp_lat);
        chk("issue_instr_bad", bad, 0);
        chk("reg_seen", seen, v.exp_reg);
        if (v.exp_reg) begin
            chk("reg_mask", mk, v.mask);
            chk("reg_rs0", r0, v.exp_rs0);
            chk("reg_rs1", r1, v.exp_rs1);
        end
        chk("rsp_accept", rsp_accept, v.exp_acc);
        chk("rsp_we", rsp_we, v.exp_we);
        chk("rsp_error", rsp_error, v.exp_err);
        chk("rsp_data", rsp_data, v.exp_data);
        chk("rsp_rd", rsp_rd, v.rd);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_data", rsp_data, v.exp_data);
            chk("hold_rd", rsp_rd, v.rd);
            chk("hold_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_done", rsp_valid, 0);
        chk("result_ready_idle", result_ready, 0);
        chk("req_ready_after", req_ready, 1);
        result_valid = 1'b0;
    endtask

    initial begin
        logic seen_rsp;
        tbl[0] = '{32'h0000007B, 32'h3F80, 32'h4000, 5'd5, 1, 1, 2'b11, 32'h4040, 0, 3, 0,
                   1, 32'h3F80, 32'h4000, 1, 1, 0, 32'h00004040, 7};
        tbl[1] = '{32'h1234507B, 32'hAAAA, 32'hBBBB, 5'd7, 0, 1, 2'b11, 32'hDEAD, 0, 0, 1,
                   0, 0, 0, 0, 0, 0, 0, 2};
        tbl[2] = '{32'h0000107B, 32'h11111111, 32'h22222222, 5'd3, 1, 1, 2'b01, 32'hCAFEF00D, 0, 0, 0,
                   1, 32'h11111111, 0, 1, 1, 0, 32'hCAFEF00D, 4};
        tbl[3] = '{32'h0000207B, 32'h33333333, 32'h44444444, 5'd31, 1, 0, 2'b10, 32'h5555, 0, 0, 1,
                   1, 0, 32'h44444444, 1, 0, 0, 0, 3};
        tbl[4] = '{32'h0000307B, 32'h1, 32'h2, 5'd1, 1, 1, 2'b00, 32'h89ABCDEF, 2, 1, 0,
                   0, 0, 0, 1, 1, 0, 32'h89ABCDEF, 6};
        tbl[5] = '{32'h0000407B, 32'h5, 32'h6, 5'd9, 1, 0, 2'b00, 32'h77, 0, 0, 1,
                   0, 0, 0, 1, 0, 0, 0, 2};
        tbl[6] = '{32'h0000507B, 32'h7, 32'h8, 5'd10, 1, 1, 2'b11, 32'h99, 999, 0, 1,
                   0, 0, 0, 0, 0, 1, 0, 256};
        tbl[7] = '{32'h0000607B, 32'h9, 32'hA, 5'd11, 1, 0, 2'b00, 32'h0, 254, 0, 0,
                   0, 0, 0, 1, 0, 0, 0, 256};
        tbl[8] = '{32'h0000707B, 32'hB, 32'hC, 5'd12, 1, 1, 2'b00, 32'h0, 0, 999, 0,
                   0, 0, 0, 1, 0, 1, 0, 257};

        #1;
        chk("rst_outs", {issue_valid, register_valid, result_ready, rsp_valid, req_ready, rsp_we, rsp_accept}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("req_ready_release", req_ready, 1);

        foreach (tbl[i]) run(tbl[i], 0);

        // Reset while waiting for a result: transaction must vanish without a response.
        req_valid = 1'b1; req_instr = 32'h0000807B; req_rs0 = 32'h1; req_rs1 = 32'h2; req_rd = 5'd4;
        @(negedge clk);
        req_valid = 1'b0;
        issue_ready = 1'b1; issue_resp_accept = 1'b1; issue_resp_writeback = 1'b1; issue_resp_register_read = 2'b00;
        @(negedge clk);
        issue_ready = 1'b0;
        chk("waitres_reached", result_ready, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", {issue_valid, register_valid, result_ready, rsp_valid, req_ready, rsp_we, rsp_accept}, 0);
        chk("rst_mid_data", rsp_data, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        result_valid = 1'b1; result_data = 32'h12345678;
        seen_rsp = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) seen_rsp = 1'b1;
        end
        result_valid = 1'b0;
        chk("rst_no_rsp", seen_rsp, 0);
        run(tbl[0], 0);

        // Core backpressure on the response channel.
        run(tbl[2], 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
